// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses UART RX command frames into ALU operations and returns the ALU
// result to the TX path as low/high bytes. Optional inter-byte timeout: ALU_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module alu_cmd_ctrl #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FUN_W       = 4,
  parameter int unsigned       OUT_W       = 16,
  parameter logic [DATA_W-1:0] CMD_OP_AB   = DATA_W'(8'hCC),
  parameter logic [DATA_W-1:0] CMD_OP_NA   = DATA_W'(8'hDD),
  parameter int unsigned       TIMEOUT_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  input  logic [OUT_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VLD,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_READY,
  output logic              CMD_ERR,
  output logic              BUSY
);

  localparam int unsigned RES_HI_W = OUT_W - DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_ALU_RUN, S_WAIT_RES, S_SEND_LO, S_SEND_HI
  } state_t;

  if (OUT_W != 2 * DATA_W) begin : g_chk_out_w
    $error("alu_cmd_ctrl: OUT_W must equal 2*DATA_W");
  end
  if (FUN_W > DATA_W || TIMEOUT_CYC == 0) begin : g_chk_cfg
    $error("alu_cmd_ctrl: FUN_W must fit in DATA_W and TIMEOUT_CYC must be nonzero");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_W-1:0]     r_alu_a;
  logic [DATA_W-1:0]     r_alu_b;
  logic [FUN_W-1:0]      r_alu_fun;
  logic [DATA_W-1:0]     r_tx_data;
  logic [RES_HI_W-1:0]   r_res_hi;
  logic                  r_alu_en;
  logic                  r_tx_vld;
  logic                  r_busy;
  logic                  r_cmd_err;
  logic                  w_alu_en_d;
  logic                  w_tx_vld_d;
  logic                  w_busy_d;
  logic                  w_cmd_err_d;
  logic                  w_discard;
  logic                  w_to_hit;
  logic                  w_tx_xfer;

  assign w_tx_xfer = r_tx_vld & TX_READY;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;
  logic            w_to_clr;

  // Counter runs while waiting on an RX byte or on the ALU result
  always_comb begin : p_to_cond
    w_to_run = 1'b0;
    w_to_clr = 1'b0;
    case (r_state)
      S_GET_A, S_GET_B, S_GET_FUN: begin
        w_to_run = 1'b1;
        w_to_clr = RX_D_VLD;
      end
      S_WAIT_RES: begin
        w_to_run = 1'b1;
        w_to_clr = ALU_OUT_VLD;
      end
      default: ;
    endcase
  end

  assign w_to_hit = w_to_run && !w_to_clr && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST) begin : p_to_cnt
    if (!RST) begin
      r_to_cnt <= '0;
    end else if (!w_to_run || w_to_clr || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin : p_state
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_discard   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_OP_AB)      w_state_nxt = S_GET_A;
          else if (RX_P_DATA == CMD_OP_NA) w_state_nxt = S_GET_FUN;
          else                             w_discard   = 1'b1;
        end
      end
      S_GET_A: begin
        if (RX_D_VLD)      w_state_nxt = S_GET_B;
        else if (w_to_hit) w_state_nxt = S_IDLE;
      end
      S_GET_B: begin
        if (RX_D_VLD)      w_state_nxt = S_GET_FUN;
        else if (w_to_hit) w_state_nxt = S_IDLE;
      end
      S_GET_FUN: begin
        if (RX_D_VLD)      w_state_nxt = S_ALU_RUN;
        else if (w_to_hit) w_state_nxt = S_IDLE;
      end
      S_ALU_RUN: begin
        w_state_nxt = S_WAIT_RES;
        w_discard   = RX_D_VLD;
      end
      S_WAIT_RES: begin
        if (ALU_OUT_VLD || w_to_hit) w_state_nxt = S_SEND_LO;
        w_discard = RX_D_VLD;
      end
      S_SEND_LO: begin
        if (w_tx_xfer) w_state_nxt = S_SEND_HI;
        w_discard = RX_D_VLD;
      end
      S_SEND_HI: begin
        if (w_tx_xfer) w_state_nxt = S_IDLE;
        w_discard = RX_D_VLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they register in step with it
  always_comb begin : p_out
    w_alu_en_d  = 1'b0;
    w_tx_vld_d  = 1'b0;
    w_busy_d    = 1'b0;
    w_cmd_err_d = 1'b0;
    w_alu_en_d  = (w_state_nxt == S_ALU_RUN);
    w_tx_vld_d  = (w_state_nxt == S_SEND_LO) || (w_state_nxt == S_SEND_HI);
    w_busy_d    = (w_state_nxt != S_IDLE);
    w_cmd_err_d = w_discard | w_to_hit;
  end

  always_ff @(posedge CLK or negedge RST) begin : p_regs
    if (!RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_tx_data <= '0;
      r_res_hi  <= '0;
      r_alu_en  <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_alu_en  <= w_alu_en_d;
      r_tx_vld  <= w_tx_vld_d;
      r_busy    <= w_busy_d;
      r_cmd_err <= w_cmd_err_d;
      if (RX_D_VLD) begin
        case (r_state)
          S_GET_A:   r_alu_a   <= RX_P_DATA;
          S_GET_B:   r_alu_b   <= RX_P_DATA;
          S_GET_FUN: r_alu_fun <= RX_P_DATA[FUN_W-1:0];
          default: ;
        endcase
      end
      // Low byte goes straight to the TX register; high byte waits for the LO transfer
      if (r_state == S_WAIT_RES && ALU_OUT_VLD) begin
        r_tx_data <= ALU_OUT[DATA_W-1:0];
        r_res_hi  <= ALU_OUT[OUT_W-1:DATA_W];
      end else if (r_state == S_WAIT_RES && w_to_hit) begin
        r_tx_data <= '0;
        r_res_hi  <= '0;
      end else if (r_state == S_SEND_LO && w_tx_xfer) begin
        r_tx_data <= DATA_W'(r_res_hi);
      end
    end
  end

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = r_alu_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign CMD_ERR   = r_cmd_err;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: frame-level reference model with a stub ALU and TX sink around alu_cmd_ctrl.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 1023;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_D_VLD, CMD_ERR, BUSY;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_READY = 1'b1;

  always #5 CLK = ~CLK;

  alu_cmd_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
    .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: operands persist across frames; each frame expects one EN and two TX bytes
  logic [7:0]  m_a = '0, m_b = '0;
  logic [3:0]  m_fun = '0;
  int          exp_err = 0, seen_err = 0;
  logic [19:0] en_log[$];
  logic [7:0]  tx_log[$];

  int          alu_lat = 1, alu_cd = 0;
  logic [15:0] alu_ret = '0;
  bit          spur = 0;
  int          rdy_mode = 0, stall_left = 0;
  bit          prev_stall = 0, xfer_now = 0;
  logic [7:0]  prev_data = '0;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs after the edge, then drive the stub ALU and TX sink
  task automatic tick();
    bit         pre_x;
    logic [7:0] pre_d;
    pre_x = (TX_D_VLD === 1'b1) && (TX_READY === 1'b1);
    pre_d = TX_P_DATA;
    @(posedge CLK); #1;
    xfer_now = pre_x;
    if (pre_x) tx_log.push_back(pre_d);
    if (prev_stall) begin
      chk("tx_hold_vld", TX_D_VLD, 1'b1);
      chk("tx_hold_data", TX_P_DATA, prev_data);
    end
    if (ALU_EN === 1'b1) en_log.push_back({ALU_A, ALU_B, ALU_FUN});
    if (CMD_ERR === 1'b1) seen_err++;
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'($urandom);
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin
        ALU_OUT_VLD = 1'b1;
        ALU_OUT = alu_ret;
      end
    end
    if (ALU_EN === 1'b1) begin
      alu_cd = alu_lat;
      if (spur) begin
        ALU_OUT_VLD = 1'b1;
        ALU_OUT = ~alu_ret;
      end
    end
    case (rdy_mode)
      0: TX_READY = 1'b1;
      1: TX_READY = 1'($urandom_range(0, 1));
      default: begin
        if (stall_left > 0 && TX_D_VLD === 1'b1) begin
          TX_READY = 1'b0;
          stall_left--;
        end else TX_READY = 1'b1;
      end
    endcase
    prev_stall = (TX_D_VLD === 1'b1) && (TX_READY === 1'b0);
    prev_data = TX_P_DATA;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b0;
    RX_D_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;
    TX_READY = 1'b1;
    #2;
    chk({tag, "_alu_a"}, ALU_A, 8'h00);
    chk({tag, "_alu_b"}, ALU_B, 8'h00);
    chk({tag, "_alu_fun"}, ALU_FUN, 4'h0);
    chk({tag, "_alu_en"}, ALU_EN, 1'b0);
    chk({tag, "_tx_data"}, TX_P_DATA, 8'h00);
    chk({tag, "_tx_vld"}, TX_D_VLD, 1'b0);
    chk({tag, "_cmd_err"}, CMD_ERR, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    m_a = '0; m_b = '0; m_fun = '0;
    alu_cd = 0; spur = 0; prev_stall = 0;
    en_log.delete(); tx_log.delete();
    seen_err = 0; exp_err = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic bad_byte(input logic [7:0] b);
    send_byte(b);
    exp_err++;
    chk("idle_err_pulse", CMD_ERR, 1'b1);
    chk("idle_err_busy", BUSY, 1'b0);
    tick();
    chk("idle_err_once", CMD_ERR, 1'b0);
  endtask

  task automatic wait_done(input bit inj);
    bit injected;
    injected = 0;
    for (int budget = 0; budget < 200 && BUSY === 1'b1; budget++) begin
      if (inj && !injected && TX_D_VLD === 1'b1 && tx_log.size() == 1) begin
        send_byte(8'($urandom));
        injected = 1;
        exp_err++;
        chk("err_pulse_send_hi", CMD_ERR, 1'b1);
      end else tick();
    end
    chk("busy_idle", BUSY, 1'b0);
    chk("busy_drop_on_hi_xfer", xfer_now, 1'b1);
    if (inj) chk("inject_done", injected, 1'b1);
  endtask

  task automatic frame(input bit ab, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] f, input logic [15:0] ret, input int gap,
                       input int lat, input bit inj, input bit sp);
    logic [19:0] exp_en;
    en_log.delete();
    tx_log.delete();
    alu_ret = ret;
    alu_lat = lat;
    send_byte(ab ? 8'hCC : 8'hDD);
    idle(gap);
    if (ab) begin
      send_byte(a); idle(gap);
      send_byte(b); idle(gap);
      m_a = a;
      m_b = b;
    end
    m_fun = f[3:0];
    spur = sp;
    send_byte(f);
    spur = 0;
    chk("alu_en_latency", ALU_EN, 1'b1);
    exp_en = {m_a, m_b, m_fun};
    wait_done(inj);
    chk("alu_en_count", en_log.size(), 1);
    if (en_log.size() > 0) chk("alu_en_operands", en_log[0], exp_en);
    chk("tx_count", tx_log.size(), 2);
    if (tx_log.size() > 0) chk("tx_lo", tx_log[0], ret[7:0]);
    if (tx_log.size() > 1) chk("tx_hi", tx_log[1], ret[15:8]);
    chk("hold_alu_a", ALU_A, m_a);
    chk("hold_alu_b", ALU_B, m_b);
    chk("hold_alu_fun", ALU_FUN, m_fun);
    chk("err_count", seen_err, exp_err);
  endtask

  initial begin
    logic [7:0]  ra, rb, rf, rx;
    logic [15:0] rr;

    do_reset("por");

    send_byte(8'hCC);
    send_byte(8'h12);
    do_reset("mid_frame");
    frame(1, 8'h01, 8'h02, 8'h00, 16'($urandom), 0, 1, 0, 0);

    rdy_mode = 1;
    frame(1, 8'h0F, 8'h3C, 8'h05, 16'h003F, 0, 1, 0, 0);
    chk("full_op_a", ALU_A, 8'h0F);
    chk("full_op_b", ALU_B, 8'h3C);
    frame(0, 8'h00, 8'h00, 8'h06, 16'($urandom), 1, 1, 0, 0);
    chk("reuse_fun", ALU_FUN, 4'h6);

    rdy_mode = 2;
    stall_left = 5;
    frame(0, 8'h00, 8'h00, 8'h07, 16'hA55A, 0, 1, 0, 0);
    chk("stall_consumed", stall_left, 0);
    rdy_mode = 0;

    bad_byte(8'h77);
    frame(1, 8'h5A, 8'hC3, 8'hF2, 16'h9E01, 0, 2, 1, 0);

    frame(1, 8'hCC, 8'hDD, 8'hCC, 16'h1357, 0, 2, 0, 1);
    frame(0, 8'h00, 8'h00, 8'hDD, 16'hBEEF, 0, 1, 0, 1);

    rdy_mode = 2;
    stall_left = 100;
    alu_lat = 1;
    alu_ret = 16'h1234;
    send_byte(8'hCC); send_byte(8'h21); send_byte(8'h43); send_byte(8'h02);
    for (int i = 0; i < 10 && TX_D_VLD !== 1'b1; i++) tick();
    chk("mid_send_vld", TX_D_VLD, 1'b1);
    do_reset("mid_send");
    rdy_mode = 0;
    stall_left = 0;

`ifdef ALU_CMD_TIMEOUT_EN
    send_byte(8'hCC);
    send_byte(8'h11);
    idle(7);
    chk("to_not_yet", CMD_ERR, 1'b0);
    chk("to_busy", BUSY, 1'b1);
    tick();
    chk("to_err", CMD_ERR, 1'b1);
    chk("to_idle", BUSY, 1'b0);
    chk("to_a_kept", ALU_A, 8'h11);
    exp_err++;
    m_a = 8'h11;
    frame(0, 8'h00, 8'h00, 8'h00, 16'h4411, 0, 1, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do rx = 8'($urandom); while (rx == 8'hCC || rx == 8'hDD);
        bad_byte(rx);
      end
      ra = ($urandom_range(0, 7) == 0) ? 8'hCC : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'hDD : 8'($urandom);
      rf = 8'($urandom);
      rr = 16'($urandom);
      rdy_mode = $urandom_range(0, 1);
      frame($urandom_range(0, 2) != 0, ra, rb, rf, rr, $urandom_range(0, 2),
            $urandom_range(1, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
